// File: rtl/gamma_pkg.sv
// Shared types and helpers for the double-buffered gamma corrector.
// Imported by the top level and by the per-channel LUT RAM.
package gamma_pkg;

    localparam int MAX_CH = 4;

    typedef logic bank_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } swap_state_t;

    // Per-pixel side-band that travels alongside the pixel data
    typedef struct packed {
        logic  sof;
        logic  gcen;
        bank_t bank;
    } pix_ctl_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gamma_lut_ram.sv
// One channel of gamma LUT storage: simple-dual-port synchronous RAM holding both banks.
// The bank bit is the address MSB, so a bank swap is only a change of that bit.
module gamma_lut_ram
    import gamma_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  bank_t             i_wbank,
    input  logic [DATA_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  bank_t             i_rbank,
    input  logic [DATA_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 2**(DATA_W+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[{i_wbank, i_waddr}] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_re)
            r_rdata <= r_mem[{i_rbank, i_raddr}];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gamma_lut_dbuf.sv
// Multi-channel gamma corrector; video reads the active LUT bank while the host fills the
// shadow bank, and the two swap atomically on the first pixel of the next frame.
module gamma_lut_dbuf
    import gamma_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 10,
    parameter int PIPE_IN = 1,
    parameter int CH_W    = clog2_min1(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ce,
    input  logic                     i_gcen,
    input  logic                     i_in_valid,
    input  logic                     i_in_sof,
    input  logic [NUM_CH*DATA_W-1:0] i_din,
    output logic                     o_out_valid,
    output logic                     o_out_sof,
    output logic                     o_gcvalid,
    output logic [NUM_CH*DATA_W-1:0] o_dout,
    input  logic                     i_lut_wr_valid,
    output logic                     o_lut_wr_ready,
    input  logic [CH_W-1:0]          i_lut_wr_ch,
    input  logic [DATA_W-1:0]        i_lut_wr_addr,
    input  logic [DATA_W-1:0]        i_lut_wr_data,
    input  logic                     i_lut_commit,
    output logic                     o_active_bank,
    output logic                     o_swap_pending
);
    localparam int STAGES = 2;

    typedef logic [NUM_CH-1:0][DATA_W-1:0] pix_t;

    swap_state_t       r_state;
    bank_t             r_active;
    logic              r_pending;
    logic              w_swap;
    logic              w_wr_acc;
    pix_ctl_t          w_in_ctl;
    logic              w_p_vld;
    pix_ctl_t          w_p_ctl;
    pix_t              w_p_din;
    logic [STAGES:1]   r_vld_pipe;
    pix_ctl_t          r_a_ctl;
    pix_t              r_a_din;
    logic              r_b_sof;
    logic              r_b_gcen;
    pix_t              r_b_din;
    pix_t              w_q;
    logic [NUM_CH-1:0] w_we;

    // The swap is taken at the port so the SOF pixel itself is tagged with the new bank;
    // a commit arriving with that SOF is still in IDLE and waits for the next frame.
    assign w_swap = i_ce & i_in_valid & i_in_sof & (r_state == ST_PEND);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_active  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_lut_commit) begin
                        r_state   <= ST_PEND;
                        r_pending <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (w_swap) begin
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                        r_active  <= ~r_active;
                    end
                end
            endcase
        end
    end

    assign w_in_ctl = '{sof:  i_in_valid & i_in_sof,
                        gcen: i_gcen,
                        bank: w_swap ? ~r_active : r_active};

    generate
        if (PIPE_IN != 0) begin : g_pipe_in
            logic     r_p_vld;
            pix_ctl_t r_p_ctl;
            pix_t     r_p_din;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_p_vld <= 1'b0;
                    r_p_ctl <= '0;
                    r_p_din <= '0;
                end else if (i_ce) begin
                    r_p_vld <= i_in_valid;
                    r_p_ctl <= w_in_ctl;
                    r_p_din <= i_din;
                end
            end

            assign w_p_vld = r_p_vld;
            assign w_p_ctl = r_p_ctl;
            assign w_p_din = r_p_din;
        end else begin : g_no_pipe_in
            assign w_p_vld = i_in_valid;
            assign w_p_ctl = w_in_ctl;
            assign w_p_din = i_din;
        end
    endgenerate

    // Stage A latches the LUT address/bank; stage B is the RAM output register.
    // Stage B payload only moves on a valid pixel so dout/gcvalid hold across bubbles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_a_ctl    <= '0;
            r_a_din    <= '0;
            r_b_sof    <= 1'b0;
            r_b_gcen   <= 1'b0;
            r_b_din    <= '0;
        end else if (i_ce) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_p_vld};
            r_a_ctl    <= w_p_ctl;
            r_a_din    <= w_p_din;
            r_b_sof    <= r_a_ctl.sof;
            if (r_vld_pipe[1]) begin
                r_b_gcen <= r_a_ctl.gcen;
                r_b_din  <= r_a_din;
            end
        end
    end

    // Writes always land in the shadow bank; channels >= NUM_CH match no RAM and vanish.
    assign o_lut_wr_ready = ~r_pending;
    assign w_wr_acc       = i_lut_wr_valid & ~r_pending;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_we[c] = w_wr_acc && (int'(i_lut_wr_ch) == c);

            gamma_lut_ram #(.DATA_W(DATA_W)) u_ram (
                .i_clk   (i_clk),
                .i_we    (w_we[c]),
                .i_wbank (~r_active),
                .i_waddr (i_lut_wr_addr),
                .i_wdata (i_lut_wr_data),
                .i_re    (i_ce & r_vld_pipe[1]),
                .i_rbank (r_a_ctl.bank),
                .i_raddr (r_a_din[c]),
                .o_rdata (w_q[c])
            );

            assign o_dout[c*DATA_W +: DATA_W] = r_b_gcen ? w_q[c] : r_b_din[c];
        end
    endgenerate

    assign o_out_valid    = r_vld_pipe[STAGES];
    assign o_out_sof      = r_b_sof;
    assign o_gcvalid      = r_b_gcen;
    assign o_active_bank  = r_active;
    assign o_swap_pending = r_pending;

endmodule

// File: tb/tb_gamma_lut_dbuf.sv
// Bench for gamma_lut_dbuf: directed vector table plus a queue-based reference model
// of the LUT banks, swap rule and pixel stream that checks every emitted pixel.
module tb_gamma_lut_dbuf;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 10;
    localparam int CH_W   = 2;
    localparam int PW     = NUM_CH*DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1, gcen = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    logic [PW-1:0] din = '0;
    logic          out_valid, out_sof, gcvalid;
    logic [PW-1:0] dout;
    logic          lut_wr_valid = 1'b0, lut_wr_ready;
    logic [CH_W-1:0]   lut_wr_ch = '0;
    logic [DATA_W-1:0] lut_wr_addr = '0, lut_wr_data = '0;
    logic          lut_commit = 1'b0, active_bank, swap_pending;

    gamma_lut_dbuf #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PIPE_IN(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_gcen(gcen),
        .i_in_valid(in_valid), .i_in_sof(in_sof), .i_din(din),
        .o_out_valid(out_valid), .o_out_sof(out_sof), .o_gcvalid(gcvalid), .o_dout(dout),
        .i_lut_wr_valid(lut_wr_valid), .o_lut_wr_ready(lut_wr_ready),
        .i_lut_wr_ch(lut_wr_ch), .i_lut_wr_addr(lut_wr_addr), .i_lut_wr_data(lut_wr_data),
        .i_lut_commit(lut_commit), .o_active_bank(active_bank), .o_swap_pending(swap_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: two banks of per-channel tables plus the expected output stream
    typedef struct { logic sof; logic gcv; logic [PW-1:0] d; } exp_t;
    exp_t exp_q[$];
    logic [DATA_W-1:0] lut [2][NUM_CH][1<<DATA_W];
    bit m_active  = 1'b0;
    bit m_pending = 1'b0;

    function automatic logic [PW-1:0] gamma_ref(input bit bank, input bit g, input logic [PW-1:0] px);
        logic [PW-1:0] r;
        r = px;
        if (g)
            for (int c = 0; c < NUM_CH; c++)
                r[c*DATA_W +: DATA_W] = lut[bank][c][px[c*DATA_W +: DATA_W]];
        return r;
    endfunction

    function automatic logic [PW-1:0] px3(input int c2, input int c1, input int c0);
        return {DATA_W'(c2), DATA_W'(c1), DATA_W'(c0)};
    endfunction

    function automatic logic [PW-1:0] rnd_px();
        return px3($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endfunction

    // One clock: check status against the model, apply this cycle's inputs to the model
    task automatic tick();
        bit   swap;
        exp_t e;
        chk("wr_ready", lut_wr_ready, !m_pending);
        chk("active_bank", active_bank, m_active);
        chk("swap_pending", swap_pending, m_pending);
        swap = ce && in_valid && in_sof && m_pending;
        if (ce && in_valid) begin
            e.sof = in_sof;
            e.gcv = gcen;
            e.d   = gamma_ref(swap ? !m_active : m_active, gcen, din);
            exp_q.push_back(e);
        end
        if (lut_wr_valid && !m_pending && lut_wr_ch < NUM_CH)
            lut[!m_active][lut_wr_ch][lut_wr_addr] = lut_wr_data;
        if (swap) begin
            m_active  = !m_active;
            m_pending = 1'b0;
        end else if (lut_commit && !m_pending) begin
            m_pending = 1'b1;
        end
        @(negedge clk);
    endtask

    // An output is new only if the edge that produced it had ce=1
    logic ce_prev = 1'b0;
    exp_t me;
    always @(posedge clk) ce_prev <= ce;
    always @(negedge clk) begin
        if (!rst && ce_prev && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL mon_extra got an output pixel expected none");
            end else begin
                me = exp_q.pop_front();
                chk("mon_sof", out_sof, me.sof);
                chk("mon_gcvalid", gcvalid, me.gcv);
                chk("mon_dout", dout, me.d);
            end
        end
    end

    task automatic idle(input int n);
        ce = 1'b1; in_valid = 1'b0; in_sof = 1'b0; lut_commit = 1'b0; lut_wr_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input int ch, input int a, input int d);
        lut_wr_valid = 1'b1;
        lut_wr_ch    = CH_W'(ch);
        lut_wr_addr  = DATA_W'(a);
        lut_wr_data  = DATA_W'(d);
        tick();
        lut_wr_valid = 1'b0;
    endtask

    task automatic commit();
        lut_commit = 1'b1;
        tick();
        lut_commit = 1'b0;
    endtask

    task automatic pix(input bit sof, input bit g, input logic [PW-1:0] d);
        in_valid = 1'b1; in_sof = sof; gcen = g; din = d;
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    typedef struct { bit sof; bit g; logic [PW-1:0] din; logic [PW-1:0] dout; } vec_t;
    vec_t vt[8];
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   t6_addr[8];

    initial begin
        // bank1 will hold out = 1023 - in; ch0 addr 1000 and ch2 addr 5 are hit by stray writes
        vt[0] = '{1'b1, 1'b1, px3(5, 100, 1000),    px3(1018, 923, 23)};
        vt[1] = '{1'b0, 1'b0, px3(5, 100, 1000),    px3(5, 100, 1000)};
        vt[2] = '{1'b0, 1'b1, px3(0, 0, 0),         px3(1023, 1023, 1023)};
        vt[3] = '{1'b0, 1'b1, px3(1023, 1023, 1023), px3(0, 0, 0)};
        vt[4] = '{1'b0, 1'b0, px3(1023, 0, 512),    px3(1023, 0, 512)};
        vt[5] = '{1'b0, 1'b1, px3(512, 511, 1),     px3(511, 512, 1022)};
        vt[6] = '{1'b0, 1'b1, px3(1000, 1000, 1000), px3(23, 23, 23)};
        vt[7] = '{1'b1, 1'b1, px3(7, 8, 9),         px3(1016, 1015, 1014)};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_gcvalid", gcvalid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_active", active_bank, 0);
        chk("rst_pending", swap_pending, 0);
        chk("rst_ready", lut_wr_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // T1: fill bank1 with an inverting ramp, then stray writes that must not land
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 1024; a++)
                wr(c, a, 1023 - a);
        wr(3, 1000, 7);
        commit();
        chk("t1_ready_low", lut_wr_ready, 0);
        wr(2, 5, 9);
        for (int i = 0; i < 8; i++) begin
            pix(vt[i].sof, vt[i].g, vt[i].din);
            tick();
            chk("tbl_early_valid", out_valid, 0);
            tick();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_sof", out_sof, vt[i].sof);
            chk("tbl_gcvalid", gcvalid, vt[i].g);
            chk("tbl_dout", dout, vt[i].dout);
            tick();
            chk("tbl_valid_drop", out_valid, 0);
            chk("tbl_dout_hold", dout, vt[i].dout);
            chk("tbl_gcvalid_hold", gcvalid, vt[i].g);
            if (i == 0) chk("t1_active", active_bank, 1);
        end

        // Random contents for bank0 (now the shadow)
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 1024; a++)
                wr(c, a, $urandom_range(0, 1023));

        // T2: commit mid-frame, 20 non-SOF pixels stay on bank1
        commit();
        for (int i = 0; i < 20; i++) pix(1'b0, 1'($urandom_range(0, 1)), rnd_px());
        chk("t2_pending", swap_pending, 1);
        chk("t2_ready", lut_wr_ready, 0);
        idle(4);

        // T3: swap to bank0, then a commit coinciding with SOF waits for the next SOF
        pix(1'b1, 1'b1, rnd_px());
        chk("t3_active0", active_bank, 0);
        lut_commit = 1'b1;
        pix(1'b1, 1'b1, rnd_px());
        lut_commit = 1'b0;
        chk("t3_same_sof_active", active_bank, 0);
        chk("t3_same_sof_pending", swap_pending, 1);
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, rnd_px());
        pix(1'b1, 1'b1, rnd_px());
        chk("t3_next_sof_active", active_bank, 1);
        idle(4);

        // T4: ramp with gcen on alternate pixels
        for (int v = 0; v < 16; v++) pix(v == 0, (v % 2) == 0, px3(v, v, v));
        idle(4);

        // T5: ce pattern 1,0,0,1 under continuous valid; commit and an SOF during ce=0
        for (int i = 0; i < 40; i++) begin
            ce = pat[i % 4]; in_valid = 1'b1; in_sof = (i == 9 || i == 12);
            gcen = 1'($urandom_range(0, 1)); din = rnd_px(); lut_commit = (i == 5);
            tick();
        end
        idle(4);
        chk("t5_active", active_bank, 0);

        // T6: write bank1, commit, reset with pixels in flight
        for (int k = 0; k < 8; k++) begin
            t6_addr[k] = 37*k + 3;
            wr(k % 3, t6_addr[k], $urandom_range(0, 1023));
        end
        commit();
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, rnd_px());
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_active", active_bank, 0);
        chk("t6_rst_pending", swap_pending, 0);
        chk("t6_rst_ready", lut_wr_ready, 1);
        exp_q.delete();
        m_active = 1'b0;
        m_pending = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid_held", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        commit();
        for (int k = 0; k < 8; k++)
            pix(k == 0, 1'b1, px3(t6_addr[k], t6_addr[k], t6_addr[k]));
        idle(5);
        chk("t6_active", active_bank, 1);
        chk("q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
